nios2system_led_out: RTL and testbench
======================================

Name: nios2system_led_out

Overview:
- Avalon-MM slave output PIO. Drives the board LEDs from the Nios II; the write-side counterpart of the switch input PIO.
- Holds a data register with atomic bit set/clear access.
- Adds a per-bit hardware blink mode timed by a prescaler and a period counter, so software can blink LEDs without servicing a timer.
- Connects to the system interconnect as an e_avalon_slave (s1). out_port exports to the LED pins.

Parameters:
- DATA_WIDTH, 10, width of out_port and all data/mask registers.
- RESET_VALUE, 0, value of the data register after reset.
- PRESCALE, 50000, clk cycles per blink tick (1 ms at 50 MHz); must be >= 2.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  word register select.
- chipselect  input  1  slave select, qualifies writes.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  DATA_WIDTH  LED drive.

Behaviour:
- Register map (word address):
  - 0 DATA (RW)
  - 2 BLINK_MASK (RW)
  - 3 BLINK_PERIOD (RW, 16 bits, in ticks)
  - 4 OUTSET (W; reads 0)
  - 5 OUTCLEAR (W; reads 0)
  - 1, 6, 7 reserved: read 0, writes ignored.
- Write strobe = chipselect && !write_n, sampled on posedge clk. Register updates at that edge.
- Wide registers take writedata[DATA_WIDTH-1:0]. BLINK_PERIOD takes writedata[15:0]. Upper bits are ignored.
- OUTSET: DATA <= DATA | wd.
- OUTCLEAR: DATA <= DATA & ~wd.
- Only one address per cycle, so no set/clear collision.
- Read:
  - readdata <= zero-extended mux of the addressed register, every clock (clk_en constant 1).
  - Reads ignore chipselect, with 1-cycle latency.
  - Reading DATA returns the register, not the blinked out_port.
- Blink timing:
  - presc counts PRESCALE-1 down to 0, then reloads. tick = (presc == 0).
  - pcnt (16 bits): on tick, if pcnt == 0 then pcnt <= BLINK_PERIOD-1 and phase <= ~phase; else pcnt <= pcnt-1.
- BLINK_PERIOD == 0: blink disabled. phase held 0, pcnt held 0; presc keeps running.
- Write to BLINK_PERIOD:
  - phase <= 0, presc <= PRESCALE-1, pcnt <= new value - 1 (0 if the new value is 0).
  - Takes priority over a tick in the same cycle.
- Result: with period P != 0, each phase lasts exactly P*PRESCALE cycles after the write.
- out_port = DATA & ~(BLINK_MASK & {DATA_WIDTH{phase}}), registered, updating one cycle after any DATA/MASK/phase change.
  - Blinked bits show DATA during phase 0 and are forced off during phase 1.
  - Bits with mask 0 are steady.
- Writes to DATA, OUTSET, OUTCLEAR and BLINK_MASK do not disturb presc, pcnt or phase.
- Reset (asynchronous, any time including mid-blink):
  - DATA=RESET_VALUE, BLINK_MASK=0, BLINK_PERIOD=0, presc=PRESCALE-1, pcnt=0, phase=0.
  - readdata=0, out_port=RESET_VALUE.
- Wrap-around: pcnt and presc never underflow, because they reload at 0. BLINK_PERIOD=0xFFFF is legal.

Test Plan:
- Reset, then write DATA=0x2A5 -> out_port=0x2A5 one cycle after the write edge. Read addr 0 -> readdata=0x000002A5 one cycle after the address is presented. Read addr 1 -> 0.
- DATA=0x00F, OUTSET 0x300 -> DATA=0x30F. OUTCLEAR 0x003 -> DATA=0x30C. Read of addr 4 or 5 -> 0. Write with chipselect=0 -> no change.
- PRESCALE=4, DATA=0x3FF, MASK=0x001, PERIOD=2 -> out_port[0] stays 1 for 8 cycles, then 0 for 8 cycles, repeating; out_port[9:1] steady 1.
- Mid-blink (phase=1), write PERIOD=3 -> phase returns to 0 and out_port[0]=1 next cycle; next toggle after exactly 12 cycles. PERIOD=0 -> out_port[0] steady at DATA[0].
- Write writedata=0xFFFFFFFF to DATA -> readdata=0x000003FF (upper bits dropped).
- Assert reset_n low asynchronously mid-phase -> out_port=RESET_VALUE and readdata=0 immediately. After release, no blinking until BLINK_PERIOD is rewritten.

Source files
------------

// File: rtl/nios2system_led_out_if.sv
// Avalon-MM slave bus bundle for the LED output PIO (s1 port).
// Latency: n/a (wires only); readdata is registered inside the slave.
// Backpressure: none; the slave accepts every write and never stalls reads.
//
// Signals: address[2:0] word select, chipselect qualifies writes,
//          write_n active-low strobe, writedata[31:0], readdata[31:0].
interface nios2system_led_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios2system_led_out.sv
// LED output PIO: data register with set/clear aliases plus per-bit hardware blink.
// Latency: register writes land at the write edge; out_port and readdata lag one cycle.
// Backpressure: none; every write is accepted, reads are always valid one cycle later.
//
// Ports: clk, reset_n (async active-low), bus (Avalon-MM slave s1),
//        out_port[DATA_WIDTH-1:0] registered LED drive.
// Register map: 0 DATA, 2 BLINK_MASK, 3 BLINK_PERIOD (16b, ticks),
//               4 OUTSET (W), 5 OUTCLEAR (W); 1/6/7 reserved.
module nios2system_led_out #(
    parameter int DATA_WIDTH  = 10,
    parameter int RESET_VALUE = 0,
    parameter int PRESCALE    = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios2system_led_out_if.slave  bus,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0]         PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [DATA_WIDTH-1:0] RST_DATA  = DATA_WIDTH'(RESET_VALUE);

    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_MASK     = 3'd2;
    localparam logic [2:0] A_PERIOD   = 3'd3;
    localparam logic [2:0] A_OUTSET   = 3'd4;
    localparam logic [2:0] A_OUTCLEAR = 3'd5;

    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic [DATA_WIDTH-1:0] mask_q,   mask_d;
    logic [15:0]           period_q, period_d;
    logic [PW-1:0]         presc_q,  presc_d;
    logic [15:0]           pcnt_q,   pcnt_d;
    logic                  phase_q,  phase_d;
    logic [DATA_WIDTH-1:0] out_q,    out_d;
    logic [31:0]           readdata_q, readdata_d;

    logic                  wr_en;
    logic                  tick;
    logic [DATA_WIDTH-1:0] wd;
    logic [15:0]           wd16;

    always_comb begin
        wr_en      = bus.chipselect && !bus.write_n;
        wd         = bus.writedata[DATA_WIDTH-1:0];
        wd16       = bus.writedata[15:0];
        tick       = (presc_q == '0);

        data_d     = data_q;
        mask_d     = mask_q;
        period_d   = period_q;
        pcnt_d     = pcnt_q;
        phase_d    = phase_q;
        presc_d    = tick ? PRESC_MAX : presc_q - 1'b1;

        // Blink engine: a zero period parks the phase counter and phase;
        // otherwise the period counter steps once per prescaler tick.
        if (period_q == 16'd0) begin
            pcnt_d  = 16'd0;
            phase_d = 1'b0;
        end else if (tick) begin
            if (pcnt_q == 16'd0) begin
                pcnt_d  = period_q - 16'd1;
                phase_d = ~phase_q;
            end else begin
                pcnt_d  = pcnt_q - 16'd1;
            end
        end

        // Bus writes. A period write restarts the whole blink timebase so the
        // first phase after it lasts exactly period*PRESCALE cycles; it wins
        // over a tick landing on the same edge because it is applied last.
        if (wr_en) begin
            case (bus.address)
                A_DATA:     data_d = wd;
                A_MASK:     mask_d = wd;
                A_PERIOD: begin
                    period_d = wd16;
                    presc_d  = PRESC_MAX;
                    phase_d  = 1'b0;
                    pcnt_d   = (wd16 == 16'd0) ? 16'd0 : wd16 - 16'd1;
                end
                A_OUTSET:   data_d = data_q | wd;
                A_OUTCLEAR: data_d = data_q & ~wd;
                default:    data_d = data_q;
            endcase
        end

        // Reads ignore chipselect and return the stored DATA, not the blinked pins.
        case (bus.address)
            A_DATA:   readdata_d = 32'(data_q);
            A_MASK:   readdata_d = 32'(mask_q);
            A_PERIOD: readdata_d = 32'(period_q);
            default:  readdata_d = 32'd0;
        endcase

        // Blinked bits are forced off during phase 1.
        out_d = data_q & ~(mask_q & {DATA_WIDTH{phase_q}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RST_DATA;
            mask_q     <= '0;
            period_q   <= 16'd0;
            presc_q    <= PRESC_MAX;
            pcnt_q     <= 16'd0;
            phase_q    <= 1'b0;
            out_q      <= RST_DATA;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            phase_q    <= phase_d;
            out_q      <= out_d;
            readdata_q <= readdata_d;
        end
    end

    assign out_port     = out_q;
    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_nios2system_led_out.sv
// Bench for the LED output PIO: random bus traffic against a timing-level model,
// with literal pins on the documented scenarios.
// Inputs change 1 ns after posedge; outputs are compared on negedge.
module tb_nios2system_led_out;

    localparam int          DW = 10;
    localparam int          PS = 4;
    localparam logic [DW-1:0] RV = 10'h000;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] out_port;

    nios2system_led_out_if bus ();

    nios2system_led_out #(
        .DATA_WIDTH (DW),
        .RESET_VALUE(0),
        .PRESCALE   (PS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Literal expectations for the cycle just clocked (set by stimulus).
    bit          pin_out_vld = 1'b0;
    logic [DW-1:0] pin_out_val;
    string       pin_out_name;
    bit          pin_rd_vld = 1'b0;
    logic [31:0] pin_rd_val;
    string       pin_rd_name;

    // ---------------- behavioural model ----------------
    // Phase is derived from elapsed cycles since the last period write:
    // after n edges the phase is floor(n / (P*PS)) mod 2.
    logic [DW-1:0] m_data  = RV;
    logic [DW-1:0] m_mask  = '0;
    logic [15:0]   m_per   = 16'd0;
    longint        since   = 0;
    logic [DW-1:0] exp_out = RV;
    logic [31:0]   exp_rd  = 32'd0;
    bit            m_ph;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data  = RV;
            m_mask  = '0;
            m_per   = 16'd0;
            since   = 0;
            exp_out = RV;
            exp_rd  = 32'd0;
        end else begin
            m_ph = 1'b0;
            if (m_per != 16'd0)
                m_ph = ((since / (longint'(m_per) * PS)) % 2) == 1;
            exp_out = m_data & ~(m_mask & {DW{m_ph}});
            case (bus.address)
                3'd0:    exp_rd = {22'd0, m_data};
                3'd2:    exp_rd = {22'd0, m_mask};
                3'd3:    exp_rd = {16'd0, m_per};
                default: exp_rd = 32'd0;
            endcase
            since = since + 1;
            if (bus.chipselect && !bus.write_n) begin
                case (bus.address)
                    3'd0: m_data = bus.writedata[DW-1:0];
                    3'd2: m_mask = bus.writedata[DW-1:0];
                    3'd3: begin
                        m_per = bus.writedata[15:0];
                        since = 0;
                    end
                    3'd4: m_data = m_data | bus.writedata[DW-1:0];
                    3'd5: m_data = m_data & ~bus.writedata[DW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (out_port !== exp_out) begin
                miscompares++;
                $display("FAIL model_out @%0t: out_port=%h expected %h", $time, out_port, exp_out);
            end
            vectors++;
            if (bus.readdata !== exp_rd) begin
                miscompares++;
                $display("FAIL model_rd @%0t: readdata=%h expected %h", $time, bus.readdata, exp_rd);
            end
            if (pin_out_vld) begin
                vectors++;
                if (out_port !== pin_out_val) begin
                    miscompares++;
                    $display("FAIL %s @%0t: out_port=%h expected %h", pin_out_name, $time, out_port, pin_out_val);
                end
            end
            if (pin_rd_vld) begin
                vectors++;
                if (bus.readdata !== pin_rd_val) begin
                    miscompares++;
                    $display("FAIL %s @%0t: readdata=%h expected %h", pin_rd_name, $time, bus.readdata, pin_rd_val);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        pin_out_vld = 1'b0;
        pin_rd_vld  = 1'b0;
    endtask

    task automatic pin_o(input string name, input logic [DW-1:0] val);
        pin_out_name = name;
        pin_out_val  = val;
        pin_out_vld  = 1'b1;
    endtask

    task automatic pin_r(input string name, input logic [31:0] val);
        pin_rd_name = name;
        pin_rd_val  = val;
        pin_rd_vld  = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        bus.address = a;
        tick();
    endtask

    initial begin
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        #1 reset_n = 1'b0;
        tick();
        chk_en = 1'b1;
        pin_o("reset_out", RV);
        pin_r("reset_rd", 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Data write and readback
        wr(3'd0, 32'h2A5);
        tick();
        pin_o("data_out", 10'h2A5);
        rd(3'd0);
        pin_r("rd_data", 32'h0000_02A5);
        rd(3'd1);
        pin_r("rd_rsvd1", 32'd0);

        // Set / clear aliases
        wr(3'd0, 32'h00F);
        wr(3'd4, 32'h300);
        rd(3'd0);
        pin_r("outset", 32'h30F);
        wr(3'd5, 32'h003);
        rd(3'd0);
        pin_r("outclear", 32'h30C);
        rd(3'd4);
        pin_r("rd_outset", 32'd0);
        rd(3'd5);
        pin_r("rd_outclear", 32'd0);

        // Write without chipselect is ignored
        bus.address   = 3'd0;
        bus.writedata = 32'd0;
        bus.write_n   = 1'b0;
        tick();
        bus.write_n = 1'b1;
        tick();
        pin_r("cs_low_ignored", 32'h30C);

        // Upper write bits dropped
        wr(3'd0, 32'hFFFF_FFFF);
        rd(3'd0);
        pin_r("wide_trunc", 32'h0000_03FF);

        // Blink: period 2 ticks of 4 cycles -> 8 cycles on, 8 off
        wr(3'd2, 32'h001);
        wr(3'd3, 32'd2);
        for (int k = 1; k <= 12; k++) begin
            tick();
            pin_o($sformatf("blink_k%0d", k), (k <= 8) ? 10'h3FF : 10'h3FE);
        end

        // Mid phase-1 period rewrite restarts the timebase
        wr(3'd3, 32'd3);
        pin_o("restart_k0", 10'h3FE);
        for (int k = 1; k <= 13; k++) begin
            tick();
            pin_o($sformatf("restart_k%0d", k), (k <= 12) ? 10'h3FF : 10'h3FE);
        end

        // Period 0 disables blinking
        wr(3'd3, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            pin_o("disabled", 10'h3FF);
        end

        // Asynchronous reset in the middle of phase 1
        wr(3'd3, 32'd2);
        repeat (10) tick();
        #1 reset_n = 1'b0;
        pin_o("async_rst_out", RV);
        pin_r("async_rst_rd", 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        wr(3'd0, 32'h3FF);
        wr(3'd2, 32'h3FF);
        for (int k = 1; k <= 40; k++) begin
            tick();
            pin_o("no_blink_after_rst", 10'h3FF);
        end

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.address   = 3'($urandom_range(0, 7));
            bus.writedata = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                bus.chipselect = ($urandom_range(0, 4) != 0);
                bus.write_n    = 1'b0;
                if (bus.address == 3'd3)
                    bus.writedata = 32'($urandom_range(0, 3));
            end else begin
                bus.chipselect = 1'($urandom_range(0, 1));
                bus.write_n    = 1'b1;
            end
            tick();
        end
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        tick();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
